// File: rtl/sdram_arbit.sv
// sdram_arbit: fixed-priority (refresh > write > read) owner of the SDRAM command pins, with internal refresh timer.
// Define REF_MISS_CNT_EN to build the saturating missed-refresh counter on ref_miss_cnt.
module sdram_arbit #(
  parameter int REF_PERIOD = 780,
  parameter int ADDR_W     = 13,
  parameter int BA_W       = 2
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  output logic              aref_en,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic              wr_end,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic              rd_end,
  output logic              ref_pending,
  output logic [2:0]        state_o,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [7:0]        ref_miss_cnt
);
  typedef enum logic [2:0] {INIT = 3'd0, ARBIT = 3'd1, AREF = 3'd2, WRITE = 3'd3, READ = 3'd4} state_t;
  localparam logic [3:0] NOP = 4'b0111;
  localparam int TW = $clog2(REF_PERIOD);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic ref_pending_q, ref_pending_d, aref_en_q, aref_en_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d, cke_q;
  logic [3:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BA_W-1:0] ba_q, ba_d;
  logic wrap, grant_ref, in_arbit;
  always_comb begin
    wrap = init_end && tmr_q == TW'(REF_PERIOD - 1);
    tmr_d = (!init_end || wrap) ? '0 : tmr_q + 1'b1;
    in_arbit = state_q == ARBIT;
    grant_ref = in_arbit && ref_pending_q;
    // a wrap coinciding with the grant re-arms the request instead of losing it
    ref_pending_d = wrap || (ref_pending_q && !grant_ref);
    aref_en_d = grant_ref;
    wr_en_d = in_arbit && !ref_pending_q && wr_req;
    rd_en_d = in_arbit && !ref_pending_q && !wr_req && rd_req;
    state_d = state_q;
    case (state_q)
      INIT:    state_d = init_end ? ARBIT : INIT;
      ARBIT:   state_d = ref_pending_q ? AREF : wr_req ? WRITE : rd_req ? READ : ARBIT;
      AREF:    state_d = aref_end ? ARBIT : AREF;
      WRITE:   state_d = wr_end ? ARBIT : WRITE;
      READ:    state_d = rd_end ? ARBIT : READ;
      default: state_d = INIT;
    endcase
    cmd_d = state_q == INIT ? init_cmd : state_q == AREF ? aref_cmd :
            state_q == WRITE ? wr_cmd : state_q == READ ? rd_cmd : NOP;
    addr_d = state_q == INIT ? init_addr : state_q == AREF ? aref_addr :
             state_q == WRITE ? wr_addr : state_q == READ ? rd_addr : '0;
    ba_d = state_q == WRITE ? wr_ba : state_q == READ ? rd_ba : '0;
  end
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      state_q       <= INIT;
      tmr_q         <= '0;
      ref_pending_q <= 1'b0;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      cke_q         <= 1'b0;
      cmd_q         <= NOP;
      addr_q        <= '0;
      ba_q          <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      ref_pending_q <= ref_pending_d;
      aref_en_q     <= aref_en_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      cke_q         <= 1'b1;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      ba_q          <= ba_d;
    end
`ifdef REF_MISS_CNT_EN
  logic [7:0] miss_q, miss_d;
  always_comb miss_d = (wrap && ref_pending_q && !grant_ref && miss_q != 8'hff) ? miss_q + 1'b1 : miss_q;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) miss_q <= '0;
    else miss_q <= miss_d;
  assign ref_miss_cnt = miss_q;
`else
  assign ref_miss_cnt = '0;
`endif
  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign ref_pending = ref_pending_q;
  assign state_o     = state_q;
  assign sdram_cke   = cke_q;
  assign sdram_cmd   = cmd_q;
  assign sdram_addr  = addr_q;
  assign sdram_ba    = ba_q;
endmodule
